// File: rtl/orao_pkg.sv
// Shared types and default cassette timing for the Orao tape player.
package orao_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_GAP  = 3'd4
  } tape_state_e;

  localparam int DEF_HALF_0    = 500;
  localparam int DEF_HALF_1    = 250;
  localparam int DEF_GAP_TICKS = 2000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/orao_byte_fifo.sv
// Byte FIFO between the download port and the tape serializer; flush wins over
// pop, and a push in the flush cycle lands in the freshly emptied FIFO.
module orao_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_base, rd_base;
  logic [AW:0]   count_q, count_d, cnt_base;
  logic          do_push, do_pop;

  assign full        = (count_q == (AW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= (AW+1)'(DEPTH - 1));
  assign count       = count_q;
  assign dout        = mem_q[rd_ptr_q];

  always_comb begin
    wr_base  = flush ? '0 : wr_ptr_q;
    rd_base  = flush ? '0 : rd_ptr_q;
    cnt_base = flush ? '0 : count_q;
    do_push  = push && (flush || !full);
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_base + AW'(do_push);
    rd_ptr_d = rd_base + AW'(do_pop);
    count_d  = cnt_base + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_base] <= din;
  end

endmodule

// File: rtl/orao_tape_player.sv
// Streams downloaded TAP bytes to the Orao cassette input as FSK pulses,
// LSB first: '0' is one long period, '1' is two short periods.
module orao_tape_player
  import orao_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int HALF_0     = DEF_HALF_0,
  parameter int HALF_1     = DEF_HALF_1,
  parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  input  logic       play,
  output logic       tape_bit,
  output logic       busy,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(max3(HALF_0, HALF_1, GAP_TICKS) + 1);

  tape_state_e   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d, half_m1;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          per_q, per_d;
  logic [7:0]    shift_q, shift_d;
  logic          dl_q, dl_rise, overflow_q, overflow_d, wait_q;
  logic          fifo_pop, fifo_full, fifo_empty, fifo_afull;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;

  assign dl_rise = ioctl_download && !dl_q;

  orao_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk_sys),
    .rst_n       (reset_n),
    .flush       (dl_rise),
    .push        (ioctl_wr),
    .pop         (fifo_pop),
    .din         (ioctl_dout),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (fifo_afull),
    .count       (fifo_count)
  );

  assign half_m1    = shift_q[0] ? TW'(HALF_1 - 1) : TW'(HALF_0 - 1);
  assign overflow_d = dl_rise ? 1'b0 : (overflow_q || (ioctl_wr && fifo_full));

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    per_d     = per_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    if (dl_rise) begin
      state_d   = ST_IDLE;
      tick_d    = '0;
      bit_idx_d = '0;
      per_d     = 1'b0;
    end else if (play) begin
      case (state_q)
        ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
        ST_LOAD: begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          bit_idx_d = '0;
          per_d     = 1'b0;
          tick_d    = '0;
          state_d   = ST_HIGH;
        end
        ST_HIGH: if (ce_1m) begin
          if (tick_q == half_m1) begin
            tick_d  = '0;
            state_d = ST_LOW;
          end else tick_d = tick_q + TW'(1);
        end
        ST_LOW: if (ce_1m) begin
          if (tick_q == half_m1) begin
            tick_d = '0;
            // A '1' bit replays its short period once before advancing.
            if (shift_q[0] && !per_q) begin
              per_d   = 1'b1;
              state_d = ST_HIGH;
            end else begin
              per_d   = 1'b0;
              shift_d = shift_q >> 1;
              if (bit_idx_q == 3'd7) state_d = fifo_empty ? ST_GAP : ST_LOAD;
              else begin
                bit_idx_d = bit_idx_q + 3'd1;
                state_d   = ST_HIGH;
              end
            end
          end else tick_d = tick_q + TW'(1);
        end
        ST_GAP: begin
          if (!fifo_empty) begin
            tick_d  = '0;
            state_d = ST_LOAD;
          end else if (ce_1m) begin
            if (tick_q == TW'(GAP_TICKS - 1)) begin
              tick_d  = '0;
              state_d = ST_IDLE;
            end else tick_d = tick_q + TW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      per_q      <= 1'b0;
      dl_q       <= 1'b0;
      overflow_q <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      per_q      <= per_d;
      dl_q       <= ioctl_download;
      overflow_q <= overflow_d;
      wait_q     <= fifo_afull;
    end
  end

  always_ff @(posedge clk_sys) begin
    shift_q <= shift_d;
  end

  assign tape_bit   = (state_q == ST_HIGH);
  assign busy       = (fifo_count != '0) || ((state_q != ST_IDLE) && (state_q != ST_GAP));
  assign overflow   = overflow_q;
  assign ioctl_wait = wait_q;

endmodule

// File: tb/tb_orao_tape_player.sv
// Directed bench for orao_tape_player using scaled-down half-period timing.
module tb_orao_tape_player;
  localparam int DEPTH = 16;
  localparam int H0    = 20;
  localparam int H1    = 10;
  localparam int GAPT  = 80;
  localparam int LIMIT = 40000;

  logic       clk_sys = 1'b0;
  logic       reset_n, ce_1m, ioctl_download, ioctl_wr, play;
  logic [7:0] ioctl_dout;
  logic       ioctl_wait, tape_bit, busy, overflow;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] seq_b [0:31];

  orao_tape_player #(
    .FIFO_DEPTH(DEPTH), .HALF_0(H0), .HALF_1(H1), .GAP_TICKS(GAPT)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ce_1m          (ce_1m),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .play           (play),
    .tape_bit       (tape_bit),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    ce_1m = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2 ce_1m = ~ce_1m;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exhausted, got no summary, want completion");
    $fatal(1);
  end

  task automatic push(input logic [7:0] b);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_dout = b;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic dl_pulse(input bit with_byte, input logic [7:0] b);
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1; ioctl_wr = with_byte; ioctl_dout = b;
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
  endtask

  // Counts qualified ticks while tape_bit holds lvl; returns on the first
  // negedge sample showing the opposite level.
  task automatic run_len(input logic lvl, output int ticks, output bit to);
    int cyc;
    cyc = 0; ticks = 0; to = 1'b0;
    while (tape_bit === lvl) begin
      if (ce_1m && play) ticks++;
      @(negedge clk_sys);
      cyc++;
      if (cyc > LIMIT) begin to = 1'b1; break; end
    end
  endtask

  task automatic wait_high(output bit to);
    int cyc;
    cyc = 0; to = 1'b0;
    @(negedge clk_sys);
    while (tape_bit !== 1'b1) begin
      @(negedge clk_sys);
      cyc++;
      if (cyc > LIMIT) begin to = 1'b1; break; end
    end
  endtask

  // Decodes n bytes from seq_b on tape_bit; the final low must end with busy.
  task automatic check_seq(input int n, input string tag);
    bit to, last;
    int t, h, np, cyc;
    wait_high(to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL %s start: got no high in %0d cycles, want pulse", tag, LIMIT);
      return;
    end
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        h  = seq_b[k][i] ? H1 : H0;
        np = seq_b[k][i] ? 2 : 1;
        for (int p = 0; p < np; p++) begin
          last = (i == 7) && (p == np - 1);
          run_len(1'b1, t, to);
          n_vec++;
          if (to || t != h) begin
            n_err++;
            $display("FAIL %s hi[%0d.%0d.%0d]: got %0d ticks, want %0d", tag, k, i, p, t, h);
            return;
          end
          if (last && k == n - 1) begin
            t = 0; cyc = 0;
            while (busy === 1'b1 && tape_bit === 1'b0 && cyc <= LIMIT) begin
              if (ce_1m && play) t++;
              @(negedge clk_sys);
              cyc++;
            end
            n_vec++;
            if (t != h) begin
              n_err++;
              $display("FAIL %s tail: got %0d busy-low ticks, want %0d", tag, t, h);
            end
            n_vec++;
            if (busy !== 1'b0 || tape_bit !== 1'b0) begin
              n_err++;
              $display("FAIL %s gap: got busy=%b tape=%b, want 0 0", tag, busy, tape_bit);
            end
          end else begin
            run_len(1'b0, t, to);
            n_vec++;
            if (to || (last ? (t != h && t != h + 1) : (t != h))) begin
              n_err++;
              $display("FAIL %s lo[%0d.%0d.%0d]: got %0d ticks, want %0d", tag, k, i, p, t, h);
              return;
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_dout = 8'h00; play = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    n_vec++;
    if (tape_bit !== 1'b0) begin n_err++; $display("FAIL reset tape_bit: got %b, want 0", tape_bit); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b, want 0", busy); end
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b, want 0", overflow); end
    n_vec++;
    if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL reset wait: got %b, want 0", ioctl_wait); end
    reset_n = 1'b1;
  endtask

  task automatic test_zero_byte;
    play = 1'b1;
    seq_b[0] = 8'h00;
    push(8'h00);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL zero busy: got %b, want 1", busy); end
    check_seq(1, "zero");
  endtask

  task automatic test_one_byte;
    play = 1'b1;
    seq_b[0] = 8'h01;
    push(8'h01);
    check_seq(1, "one");
  endtask

  task automatic test_back_to_back;
    play = 1'b0;
    seq_b[0] = 8'hA5; seq_b[1] = 8'h3C;
    push(8'hA5);
    push(8'h3C);
    play = 1'b1;
    check_seq(2, "b2b");
  endtask

  task automatic test_burst;
    int idx, cyc;
    bit wrote;
    play = 1'b0;
    for (int k = 0; k < 20; k++) seq_b[k] = 8'(k * 37 + 11);
    fork
      begin
        idx = 0; cyc = 0;
        @(posedge clk_sys); #1;
        while (idx < 20 && cyc < LIMIT) begin
          wrote = 1'b0;
          if (!ioctl_wait) begin
            ioctl_wr = 1'b1; ioctl_dout = seq_b[idx]; idx++; wrote = 1'b1;
          end else ioctl_wr = 1'b0;
          @(posedge clk_sys); #1;
          cyc++;
          if (wrote && idx == 15) begin
            n_vec++;
            if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL burst wait@15: got %b, want 0", ioctl_wait); end
          end
          if (wrote && idx == 16) begin
            n_vec++;
            if (ioctl_wait !== 1'b1) begin n_err++; $display("FAIL burst wait@16: got %b, want 1", ioctl_wait); end
            play = 1'b1;
          end
        end
        ioctl_wr = 1'b0;
        n_vec++;
        if (idx != 20) begin n_err++; $display("FAIL burst writes: got %0d, want 20", idx); end
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL burst overflow: got %b, want 0", overflow); end
      end
      check_seq(20, "burst");
    join
  endtask

  task automatic test_overflow;
    play = 1'b0;
    dl_pulse(1'b0, 8'h00);
    for (int k = 0; k < 16; k++) begin
      seq_b[k] = 8'(k * 29 + 3);
      push(seq_b[k]);
    end
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf before: got %b, want 0", overflow); end
    push(8'hEE);
    n_vec++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf set: got %b, want 1", overflow); end
    play = 1'b1;
    check_seq(16, "ovf");
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (30) @(posedge clk_sys);
    #1;
    n_vec++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf sticky: got %b, want 1", overflow); end
    dl_pulse(1'b1, 8'h80);
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf clear: got %b, want 0", overflow); end
    seq_b[0] = 8'h80;
    check_seq(1, "flush");
  endtask

  task automatic test_pause;
    bit to;
    int t, bad;
    play = 1'b1;
    push(8'h00);
    wait_high(to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL pause start: got no high, want pulse"); return; end
    bad = 0;
    fork
      run_len(1'b1, t, to);
      begin
        repeat (6) @(posedge clk_sys);
        #1 play = 1'b0;
        repeat (600) begin
          @(negedge clk_sys);
          if (tape_bit !== 1'b1) bad++;
        end
        @(posedge clk_sys);
        #1 play = 1'b1;
      end
    join
    n_vec++;
    if (to || t != H0) begin n_err++; $display("FAIL pause high total: got %0d ticks, want %0d", t, H0); end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL pause hold: got %0d low samples, want 0", bad); end
    t = 0;
    while (busy === 1'b1 && t < LIMIT) begin @(negedge clk_sys); t++; end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL pause drain: got busy=%b, want 0", busy); end
  endtask

  task automatic test_reset_mid;
    bit to;
    int bad;
    play = 1'b1;
    push(8'hFF);
    wait_high(to);
    repeat (7) @(negedge clk_sys);
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (tape_bit !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid async: got tape=%b busy=%b, want 0 0", tape_bit, busy);
    end
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk_sys);
      if (tape_bit !== 1'b0 || busy !== 1'b0 || ioctl_wait !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL rstmid quiet: got %0d active samples, want 0", bad); end
    seq_b[0] = 8'h5A;
    push(8'h5A);
    check_seq(1, "rstmid");
  endtask

  initial begin
    test_reset();
    test_zero_byte();
    test_one_byte();
    test_back_to_back();
    test_burst();
    test_overflow();
    test_pause();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/orao_tape_player.md
ORAO_TAPE_PLAYER -- requirements
Module: orao_tape_player

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO depth (power of two, 4..256).
REQ-002 SHALL have parameter HALF_0, default 500, ce_1m ticks per half-period of a '0' bit.
REQ-003 SHALL have parameter HALF_1, default 250, ce_1m ticks per half-period of a '1' bit.
REQ-004 SHALL have parameter GAP_TICKS, default 2000, ce_1m ticks of idle-low between bytes when the FIFO is empty.
REQ-005 SHALL have port clk_sys input 1: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n input 1: asynchronous, active-low reset.
REQ-007 SHALL have port ce_1m input 1: 1 MHz clock enable; all tape timing advances only when it is high.
REQ-008 SHALL have port ioctl_download input 1: TAP download active.
REQ-009 SHALL have port ioctl_wr input 1: byte strobe, one clk_sys cycle.
REQ-010 SHALL have port ioctl_dout input 8: downloaded byte.
REQ-011 SHALL have port ioctl_wait output 1: backpressure to the download source.
REQ-012 SHALL have port play input 1: playback enable; when low, the serializer holds its state.
REQ-013 SHALL have port tape_bit output 1: serial cassette level fed to the machine's tape input.
REQ-014 SHALL have port busy output 1: high while any byte is queued or being serialized.
REQ-015 SHALL have port overflow output 1: sticky error flag.

Function
REQ-016 SHALL accept a byte into the FIFO when ioctl_wr is high and the FIFO is not full; ioctl_download is not required for acceptance.
REQ-017 SHALL drive ioctl_wait high from the cycle after occupancy reaches FIFO_DEPTH-1 (registered), so one in-flight write still fits.
REQ-018 SHALL set overflow and discard the byte on ioctl_wr while full; overflow clears only on reset or a rising edge of ioctl_download.
REQ-019 SHALL evaluate a simultaneous push and pop in the same cycle as both succeeding, with occupancy unchanged.
REQ-020 SHALL implement the states IDLE, LOAD, HIGH, LOW and GAP.
REQ-021 IDLE SHALL go to LOAD when the FIFO is non-empty and play is high, and SHALL hold tape_bit low.
REQ-022 LOAD SHALL pop one byte into a shift register in one cycle, set the bit index to 0 and go to HIGH; it SHALL not wait for ce_1m.
REQ-023 SHALL serialize bits LSB first.
REQ-024 SHALL encode a '0' bit as one period, tape_bit high for HALF_0 ticks then low for HALF_0 ticks.
REQ-025 SHALL encode a '1' bit as two periods, each high for HALF_1 ticks then low for HALF_1 ticks.
REQ-026 SHALL make every bit last exactly 2*HALF_0 ticks with the default parameters.
REQ-027 SHALL, after the last LOW of bit 7, go to LOAD if the FIFO is non-empty; otherwise it SHALL go to GAP.
REQ-028 GAP SHALL hold tape_bit low for GAP_TICKS ticks, then go to IDLE, or go to LOAD at once if a byte arrives during GAP.
REQ-029 SHALL freeze the tick counter and state while play is low, keeping tape_bit at its current level.
REQ-030 SHALL set busy = (FIFO non-empty) OR (state not IDLE and not GAP).
REQ-031 SHALL make the tick counter wide enough for max(HALF_0, HALF_1, GAP_TICKS) with no wrap-around.
REQ-032 SHALL flush the FIFO, return to IDLE and drive tape_bit low on a rising edge of ioctl_download; bytes in that same cycle SHALL be accepted after the flush.

Reset
REQ-033 SHALL, while reset_n is low, asynchronously force: state IDLE, FIFO empty, tape_bit 0, busy 0, overflow 0, ioctl_wait 0, all counters 0.
REQ-034 SHALL abandon any byte being serialized on reset mid-byte; no partial bit SHALL be emitted after reset_n rises.

Structure
REQ-035 SHALL place the state enumeration and the default HALF_0/HALF_1/GAP_TICKS constants in shared package orao_pkg.
REQ-036 SHALL implement the FIFO as sub-module orao_byte_fifo (push, pop, full, empty, almost_full, count), with the serializer FSM in the top module.

Verification
REQ-037 SHALL pass: push byte 0x00 with play=1 -> 8 periods of 500 high/500 low ticks, then GAP for 2000 ticks, busy high until GAP entry.
REQ-038 SHALL pass: push 0x01 -> first bit is two 250/250 periods, followed by seven 500/500 periods.
REQ-039 SHALL pass: burst 20 writes with FIFO_DEPTH=16 while honouring ioctl_wait -> ioctl_wait rises after the 15th write, overflow stays 0, and all 20 bytes are serialized in order.
REQ-040 SHALL pass: write while full ignoring ioctl_wait -> overflow=1 and the byte is dropped; a new ioctl_download rise clears overflow.
REQ-041 SHALL pass: play=0 for 300 ticks mid-HIGH -> tape_bit stays 1 and the high phase resumes to a total of 500 counted ticks.
REQ-042 SHALL pass: reset_n low mid-byte for 1 cycle -> tape_bit=0, busy=0 and FIFO empty immediately, with no output activity afterwards until a new push.
